popcount_rr_sched: RTL and testbench

//  Shares one shifter + counter_127 popcount datapath among N_REQ requesters.
//  A round-robin arbiter picks one request per cycle. Its 127-bit word is shifted by
//  the requester's amount, then its ones are counted.
//  The result returns on a valid/ready output port, tagged with the requester id.
//  2-stage pipeline: S1 = shifted word, S2 = count. Sits between client blocks and
//  the shared datapath.

---
 rtl/popcnt_pkg.sv | 38 +++
 rtl/counter_127.sv | 16 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/shifter.sv | 20 ++
 rtl/popcount_rr_sched.sv | 126 ++++++++++++
 tb/tb_popcount_rr_sched.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/popcnt_pkg.sv
// Shared types and the rotating find-first helper for the popcount scheduler.
package popcnt_pkg;

    localparam int unsigned WIDTH   = 127;
    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam int unsigned MAX_REQ = 8;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [CW-1:0]    cnt_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate the index back.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input int unsigned        n,
                                      input logic [2:0]         ptr);
        logic [MAX_REQ-1:0] rot;
        pick_t              res;
        rot = '0;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                rot[i] = req[3'((32'(ptr) + i) % n)];
            end
        end
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (rot[i] && !res.found) begin
                res.found = 1'b1;
                res.idx   = 3'((i + 32'(ptr)) % n);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_127.sv
// Combinational population count of a 127-bit word.
module counter_127
    import popcnt_pkg::*;
(
    input  word_t din,
    output cnt_t  count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + cnt_t'(din[i]);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant when enabled, pointer moves past the winner.
module rr_arbiter
    import popcnt_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             gnt_vld
);

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [MAX_REQ-1:0] req_pad;
    logic [2:0]         ptr_pad;
    pick_t              pick;

    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = req;
        ptr_pad              = '0;
        ptr_pad[IDW-1:0]     = ptr_q;
        pick                 = rr_pick(req_pad, N_REQ, ptr_pad);

        gnt     = '0;
        gnt_vld = en & pick.found;
        gnt_idx = pick.idx[IDW-1:0];
        ptr_d   = ptr_q;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
            ptr_d        = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shifter.sv
// Logical left shift with zero fill; amounts at or beyond the word width give zero.
module shifter #(
    parameter int unsigned WIDTH = 127,
    parameter int unsigned SW    = 7
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    amt,
    output logic [WIDTH-1:0] dout
);

    localparam logic [SW:0] LIMIT = (SW + 1)'(WIDTH);

    always_comb begin
        dout = '0;
        if ({1'b0, amt} < LIMIT) begin
            dout = din << amt;
        end
    end

endmodule

// File: rtl/popcount_rr_sched.sv
// Round-robin shared shift+popcount datapath: S1 holds the shifted word, S2 the count.
module popcount_rr_sched
    import popcnt_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = popcnt_pkg::WIDTH,
    parameter int unsigned CW    = popcnt_pkg::CW,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][WIDTH-1:0] data,
    input  logic [N_REQ-1:0][CW-1:0]    sh,
    output logic [N_REQ-1:0]            gnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CW-1:0]               out_count,
    output logic [IDW-1:0]              out_id
);

    logic           s2_adv;
    logic           s1_adv;
    logic           arb_en;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;

    logic [WIDTH-1:0] sel_data;
    logic [CW-1:0]    sel_sh;
    logic [WIDTH-1:0] shifted;
    cnt_t             s1_cnt;

    word_t          s1_word_q, s1_word_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s1_v_q, s1_v_d;
    logic           s2_v_q, s2_v_d;
    cnt_t           cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;

    // Kept apart from the next-state block: the grant loops back through the arbiter.
    always_comb begin
        s2_adv = !s2_v_q || out_ready;
        s1_adv = !s1_v_q || s2_adv;
        arb_en = s1_adv && !rst;
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_data = data[gnt_idx];
        sel_sh   = sh[gnt_idx];
    end

    shifter #(
        .WIDTH (WIDTH),
        .SW    (CW)
    ) u_shift (
        .din  (sel_data),
        .amt  (sel_sh),
        .dout (shifted)
    );

    counter_127 u_cnt (
        .din   (s1_word_q),
        .count (s1_cnt)
    );

    always_comb begin
        s1_word_d = s1_word_q;
        s1_id_d   = s1_id_q;
        s1_v_d    = s1_v_q;
        s2_v_d    = s2_v_q;
        cnt_d     = cnt_q;
        id_d      = id_q;

        if (gnt_vld) begin
            s1_word_d = shifted;
            s1_id_d   = gnt_idx;
            s1_v_d    = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            cnt_d  = s1_cnt;
            id_d   = s1_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_word_q <= '0;
            s1_id_q   <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            cnt_q     <= '0;
            id_q      <= '0;
        end else begin
            s1_word_q <= s1_word_d;
            s1_id_q   <= s1_id_d;
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        out_valid = s2_v_q;
        out_count = cnt_q;
        out_id    = id_q;
    end

endmodule

// File: tb/tb_popcount_rr_sched.sv
// Directed and randomized check of popcount_rr_sched against a queue-based model.
module tb_popcount_rr_sched;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][126:0]   data;
    logic [N-1:0][6:0]     sh;
    logic [N-1:0]          gnt;
    logic                  out_valid;
    logic                  out_ready;
    logic [6:0]            out_count;
    logic [1:0]            out_id;

    logic [126:0] ones;

    typedef struct {
        int cnt;
        int id;
        bit in_s2;
    } item_t;

    item_t        q[$];
    int           ptr;
    logic [N-1:0] last_gnt;
    bit           model_on;
    int           errors;
    int           checks;

    popcount_rr_sched #(
        .N_REQ (4),
        .WIDTH (127),
        .CW    (7),
        .IDW   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .sh        (sh),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_count(input logic [126:0] d, input int s);
        logic [126:0] w;
        if (s >= 127) return 0;
        w = d << s;
        return $countones(w);
    endfunction

    // Pipeline can hold two results; it refuses new work only when full and blocked.
    function automatic int model_pick();
        if (rst || (q.size() == 2 && !out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int p;
        if (rst) begin
            q.delete();
            ptr      = 0;
            last_gnt = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            p = model_pick();
            if (q.size() > 0 && q[0].in_s2 && out_ready) void'(q.pop_front());
            if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
            last_gnt = '0;
            if (p >= 0) begin
                q.push_back('{cnt: ref_count(data[p], int'(sh[p])), id: p, in_s2: 1'b0});
                ptr         = (p + 1) % N;
                last_gnt[p] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int  p;
        bit  ev;
        #3;
        if (model_on) begin
            p  = model_pick();
            ev = (q.size() > 0) && q[0].in_s2;
            chk("gnt", 32'(gnt), (p < 0) ? 32'd0 : (32'd1 << p));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                chk("out_count", 32'(out_count), 32'(q[0].cnt));
                chk("out_id", 32'(out_id), 32'(q[0].id));
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        nxt();
        rst = 1'b0;
    endtask

    task automatic single(input string nm, input int i, input logic [126:0] d,
                          input int s, input int exp);
        req[i]  = 1'b1;
        data[i] = d;
        sh[i]   = 7'(s);
        #1 chk({nm, "_gnt"}, 32'(gnt), 32'd1 << i);
        nxt();
        req = '0;
        nxt();
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_count"}, 32'(out_count), 32'(exp));
        chk({nm, "_id"}, 32'(out_id), 32'(i));
    endtask

    initial begin
        int           gcount;
        logic [127:0] r;

        errors    = 0;
        checks    = 0;
        model_on  = 1'b0;
        ptr       = 0;
        last_gnt  = '0;
        ones      = '1;
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        data      = '0;
        sh        = '0;

        for (int c = 0; c < 2; c++) begin
            nxt();
            #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(out_count), 32'd0);
        end
        rst = 1'b0;
        req = '0;

        single("single2", 2, ones, 0, 127);
        single("sh126", 0, ones, 126, 1);
        single("sh127", 0, ones, 127, 0);
        single("zero", 0, '0, 0, 0);
        nxt();

        do_reset();
        for (int j = 0; j < 7; j++) begin
            if (j < 5) begin
                req = 4'b1111;
                for (int i = 0; i < N; i++) begin
                    r       = {$urandom, $urandom, $urandom, $urandom};
                    data[i] = r[126:0];
                    sh[i]   = 7'($urandom_range(0, 127));
                end
            end else begin
                req = '0;
            end
            #1;
            if (j < 5) chk("rr_gnt", 32'(gnt), 32'd1 << (j % 4));
            if (j >= 2) begin
                chk("rr_valid", 32'(out_valid), 32'd1);
                chk("rr_id", 32'(out_id), 32'((j - 2) % 4));
            end
            nxt();
        end

        do_reset();
        req       = 4'b0011;
        data[0]   = ones;
        sh[0]     = 7'd0;
        data[1]   = ones;
        sh[1]     = 7'd100;
        out_ready = 1'b0;
        gcount    = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            if (gnt != '0) gcount++;
            chk("bp_gnt", 32'(gnt), (j == 0) ? 32'd1 : (j == 1) ? 32'd2 : 32'd0);
            if (j >= 2) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_id", 32'(out_id), 32'd0);
                chk("bp_hold_count", 32'(out_count), 32'd127);
            end
            nxt();
        end
        chk("bp_grants", 32'(gcount), 32'd2);
        out_ready = 1'b1;
        req       = '0;
        #1 chk("bp_first_id", 32'(out_id), 32'd0);
        chk("bp_first_count", 32'(out_count), 32'd127);
        nxt();
        #1 chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_id", 32'(out_id), 32'd1);
        chk("bp_second_count", 32'(out_count), 32'd27);
        nxt();
        #1 chk("bp_drained", 32'(out_valid), 32'd0);

        do_reset();
        out_ready = 1'b0;
        req       = 4'b1111;
        nxt();
        nxt();
        #1 chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("mid_rst_gnt", 32'(gnt), 32'd0);
        nxt();
        rst       = 1'b0;
        req       = 4'b0110;
        out_ready = 1'b1;
        #1 chk("mid_after_valid", 32'(out_valid), 32'd0);
        chk("mid_after_gnt", 32'(gnt), 32'd2);
        nxt();
        req = '0;
        nxt();
        nxt();

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && last_gnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: data[i] = ones;
                        1: data[i] = '0;
                        2: begin
                            r       = {$urandom, $urandom, $urandom, $urandom};
                            data[i] = r[126:0];
                        end
                        default: begin
                            data[i] = '0;
                            data[i][$urandom_range(0, 126)] = 1'b1;
                        end
                    endcase
                    sh[i] = 7'($urandom_range(0, 127));
                end
            end
            nxt();
        end

        rst       = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) nxt();
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
